// File: rtl/elevator_request_scheduler.sv
// Elevator request scheduler for a three-floor car (F1..F3).
// The block latches car and hall button presses and sweeps the car between
// floors with a one-floor-per-move_ack motor handshake. It also times the
// door dwell.
// Optional build macro: DOOR_HOLD_EXT_EN adds a door_hold input. While that
// input is high the door stays open, and the dwell restarts after it is released.
// Floor encoding is one-hot with bit2=F1, bit1=F2 and bit0=F3, so "up" moves
// the set bit toward bit0.
module elevator_request_scheduler #(
  parameter int unsigned DWELL_CYCLES = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] car_press,
  input  logic [3:0] hall_press,
`ifdef DOOR_HOLD_EXT_EN
  input  logic       door_hold,
`endif
  output logic       move_req,
  output logic       move_up,
  input  logic       move_ack,
  output logic [2:0] floor,
  output logic       door,
  output logic [2:0] car_pend,
  output logic [3:0] hall_pend
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    MOVING    = 2'd1,
    DOOR_OPEN = 2'd2
  } state_t;

  localparam logic [7:0] DWELL_LOAD = 8'(DWELL_CYCLES);

  state_t     state_q, state_d;
  logic [2:0] floor_q, floor_d;
  logic       dir_q, dir_d;
  logic [7:0] cnt_q, cnt_d;
  logic [2:0] car_q;
  logic [3:0] hall_q;

  logic [2:0] eff_car;
  logic [3:0] eff_hall;
  logic [2:0] reqs;
  logic       at_here, ahead, behind;
  logic [2:0] next_floor;
  logic       at_end, ahead_next, stop_next;
  logic       svc;
  logic [2:0] car_clr;
  logic [3:0] hall_clr;
  logic       hold_now;

`ifdef DOOR_HOLD_EXT_EN
  assign hold_now = door_hold;
`else
  assign hold_now = 1'b0;
`endif

  // Collapse the car and hall requests into one request bit per floor.
  function automatic logic [2:0] floor_reqs(input logic [2:0] car, input logic [3:0] hall);
    floor_reqs = {car[2] | hall[3], car[1] | hall[2] | hall[1], car[0] | hall[0]};
  endfunction

  // Floors strictly beyond f in a direction. "Up" means floors with a lower bit index.
  function automatic logic [2:0] beyond_mask(input logic [2:0] f, input logic up);
    logic [2:0] below;
    below = f - 3'd1;
    beyond_mask = up ? below : ~(f | below);
  endfunction

  // Hall button belonging to floor f for a travel direction. F1 has no down call and F3 has no up call.
  function automatic logic [3:0] hall_mask(input logic [2:0] f, input logic up);
    hall_mask = 4'b0000;
    case (f)
      3'b100:  hall_mask = up ? 4'b1000 : 4'b0000;
      3'b010:  hall_mask = up ? 4'b0010 : 4'b0100;
      3'b001:  hall_mask = up ? 4'b0000 : 4'b0001;
      default: hall_mask = 4'b0000;
    endcase
  endfunction

  // Service direction on arrival. The end floors force their only possible direction.
  // The sweep keeps going if work remains ahead, or if the car stopped to serve the
  // hall call of its own direction. Otherwise it turns around.
  function automatic logic arrive_dir(input logic [2:0] f, input logic up,
                                      input logic more_ahead, input logic [3:0] hall);
    if (f[2])
      arrive_dir = 1'b1;
    else if (f[0])
      arrive_dir = 1'b0;
    else if (more_ahead || (|(hall & hall_mask(f, up))))
      arrive_dir = up;
    else
      arrive_dir = ~up;
  endfunction

  // Service direction when the door opens from IDLE. A waiting hall call at this
  // floor picks the direction. This matters because keeping the sweep direction
  // while only the opposite hall call waits would reopen the door forever without
  // clearing that call.
  function automatic logic idle_dir(input logic [2:0] f, input logic up,
                                    input logic more_ahead, input logic [3:0] hall);
    if (f[2])
      idle_dir = 1'b1;
    else if (f[0])
      idle_dir = 1'b0;
    else if (|(hall & hall_mask(f, up)))
      idle_dir = up;
    else if (|(hall & hall_mask(f, ~up)))
      idle_dir = ~up;
    else if (more_ahead)
      idle_dir = up;
    else
      idle_dir = ~up;
  endfunction

  // Request view used for scheduling decisions. It includes presses arriving this cycle.
  always_comb begin
    eff_car    = car_q | car_press;
    eff_hall   = hall_q | hall_press;
    reqs       = floor_reqs(eff_car, eff_hall);
    at_here    = |(reqs & floor_q);
    ahead      = |(reqs & beyond_mask(floor_q, dir_q));
    behind     = |(reqs & beyond_mask(floor_q, ~dir_q));
    next_floor = dir_q ? {1'b0, floor_q[2:1]} : {floor_q[1:0], 1'b0};
    at_end     = dir_q ? floor_q[0] : floor_q[2];
    ahead_next = |(reqs & beyond_mask(next_floor, dir_q));
    stop_next  = (|(eff_car & next_floor)) | (|(eff_hall & hall_mask(next_floor, dir_q)))
                 | ~ahead_next;
  end

  // Next-state logic: sweep decisions, arrival stops, door dwell timing and request clearing.
  always_comb begin
    state_d  = state_q;
    floor_d  = floor_q;
    dir_d    = dir_q;
    cnt_d    = cnt_q;
    car_clr  = 3'b000;
    hall_clr = 4'b0000;
    svc      = dir_q;
    case (state_q)
      IDLE: begin
        if (at_here) begin
          svc      = idle_dir(floor_q, dir_q, ahead, eff_hall);
          dir_d    = svc;
          state_d  = DOOR_OPEN;
          cnt_d    = DWELL_LOAD;
          car_clr  = floor_q;
          hall_clr = hall_mask(floor_q, svc);
        end else if (ahead) begin
          state_d = MOVING;
        end else if (behind) begin
          dir_d   = ~dir_q;
          state_d = MOVING;
        end
      end
      MOVING: begin
        if (move_ack && !at_end) begin
          floor_d = next_floor;
          if (stop_next) begin
            svc      = arrive_dir(next_floor, dir_q, ahead_next, eff_hall);
            dir_d    = svc;
            state_d  = DOOR_OPEN;
            cnt_d    = DWELL_LOAD;
            car_clr  = next_floor;
            hall_clr = hall_mask(next_floor, svc);
          end
        end
      end
      DOOR_OPEN: begin
        car_clr  = floor_q;
        hall_clr = hall_mask(floor_q, dir_q);
        if (hold_now) begin
          cnt_d = DWELL_LOAD;
        end else if (cnt_q <= 8'd1) begin
          cnt_d   = 8'd0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, position, direction and dwell counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      floor_q <= 3'b100;
      dir_q   <= 1'b1;
      cnt_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      floor_q <= floor_d;
      dir_q   <= dir_d;
      cnt_q   <= cnt_d;
    end
  end

  // Pending-request latches. A clear always beats a press of the same bit in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      car_q  <= 3'b000;
      hall_q <= 4'b0000;
    end else begin
      car_q  <= (car_q | car_press) & ~car_clr;
      hall_q <= (hall_q | hall_press) & ~hall_clr;
    end
  end

  assign move_req  = (state_q == MOVING);
  assign move_up   = (state_q == MOVING) & dir_q;
  assign floor     = floor_q;
  assign door      = (state_q == DOOR_OPEN);
  assign car_pend  = car_q;
  assign hall_pend = hall_q;

endmodule

// File: doc/elevator_request_scheduler.md
ELEVATOR_REQUEST_SCHEDULER -- requirements
Module: elevator_request_scheduler

Interface
REQ-001 SHALL have parameter: DWELL_CYCLES, 8, door-open dwell in clk cycles (legal 2..255).
REQ-002 SHALL have port: clk  in  1  single clock, all state on rising edge.
REQ-003 SHALL have port: rst  in  1  asynchronous, active-high reset.
REQ-004 SHALL have port: car_press  in  3  car buttons, one-cycle or level; bit2=F1, bit1=F2, bit0=F3.
REQ-005 SHALL have port: hall_press  in  4  hall buttons; bit3=F1 up, bit2=F2 down, bit1=F2 up, bit0=F3 down.
REQ-006 SHALL have port: move_req  out  1  request motor to travel one floor.
REQ-007 SHALL have port: move_up  out  1  travel direction while move_req=1 (1=up).
REQ-008 SHALL have port: move_ack  in  1  one-cycle pulse: one-floor travel complete.
REQ-009 SHALL have port: floor  out  3  one-hot position, same bit order as car_press.
REQ-010 SHALL have port: door  out  1  door open.
REQ-011 SHALL have ports: car_pend out 3, hall_pend out 4  latched pending requests (lamp drive).

Function
REQ-012 SHALL latch presses: pend <= (pend | press) & ~clear every cycle; clear wins on same-cycle press of same bit.
REQ-013 SHALL hold internal direction dir (1=up); ahead = any pending request strictly beyond floor in dir.
REQ-014 SHALL implement states IDLE, MOVING, DOOR_OPEN; floor changes only in MOVING.
REQ-015 IDLE: request at current floor (car bit, or any hall bit of that floor) -> DOOR_OPEN next cycle; else ahead -> MOVING; else any request behind -> flip dir, MOVING; else stay.
REQ-016 MOVING: move_req=1, move_up=dir, stable until move_ack; on move_ack floor shifts one position in dir same edge.
REQ-017 On move_ack, arrival floor stop if car bit pending, hall bit for dir pending, or no request further ahead -> DOOR_OPEN; else remain MOVING (next floor, move_req kept high).
REQ-018 On DOOR_OPEN entry SHALL set service direction: keep dir if ahead exists, else flip; F1 forces up, F3 forces down.
REQ-019 On DOOR_OPEN entry cycle SHALL clear car bit of floor and hall bit of floor matching service direction (F2 clears exactly one of bit2/bit1).
REQ-020 DOOR_OPEN: door=1, 8-bit counter loaded DWELL_CYCLES on entry, decrements; door=1 for exactly DWELL_CYCLES cycles, then IDLE.
REQ-021 Press for current floor/service direction while DOOR_OPEN SHALL be cleared (not latched); opposite hall bit SHALL latch.
REQ-022 move_ack outside MOVING SHALL be ignored; move_req SHALL never assert with door=1.
REQ-023 move_ack at F3 with dir up (or F1 with dir down) SHALL be ignored; floor saturates.

Reset
REQ-024 On rst: state IDLE, floor=3'b100, dir=1, car_pend=0, hall_pend=0, dwell counter 0, door=0, move_req=0, move_up=0.
REQ-025 Reset mid-MOVING or mid-DOOR_OPEN SHALL take effect immediately, discarding all pending requests; first cycle after release SHALL sample presses.

Configuration
REQ-026 With DOOR_HOLD_EXT_EN defined SHALL add input door_hold (1 bit): while door_hold=1 in DOOR_OPEN, counter reloads DWELL_CYCLES; door closes DWELL_CYCLES cycles after its release.
REQ-027 Without DOOR_HOLD_EXT_EN, no door_hold port exists; dwell fixed per REQ-020.

Verification
REQ-028 After reset, car_press=3'b001 one cycle -> move_req=1,move_up=1; two move_ack -> floor=3'b001, door=1 for 8 cycles, car_pend=0, then IDLE.
REQ-029 At F1 idle, hall_press=4'b1000 -> door=1 next cycle without move_req; hall_pend bit3 cleared.
REQ-030 Moving up from F1 with car F3 and hall F2 down pending -> passes F2 (no door), stops F3, flips dir, returns to F2, clears bit2 only.
REQ-031 Moving up with hall F2 up (bit1) pending -> stops at F2, clears bit1; hall F2 down latched during dwell stays pending.
REQ-032 rst asserted during MOVING with requests pending -> floor=3'b100, all pend=0, move_req=0 same cycle (asynchronous).
REQ-033 With DOOR_HOLD_EXT_EN, door_hold held 20 cycles in DOOR_OPEN -> door=1 throughout plus 8 cycles after release.
